ram4002_responder: RTL and testbench

//  Memory-side responder for the MCS-4 bus driven by the CPU's ALU/timing boards.

---
 rtl/ram4002_responder_pkg.sv | 59 +++++
 rtl/ram4002_responder_if.sv | 13 +
 rtl/ram4002_responder_phase_seq.sv | 50 +++++
 rtl/ram4002_responder.sv | 120 ++++++++++++
 tb/tb_ram4002_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram4002_responder_pkg.sv
// Shared MCS-4 bus definitions: phase encodings, I/O opcodes, RAM geometry and
// opcode classification helpers for the 4002 responder.
package ram4002_responder_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned REG_W     = 2;
  localparam int unsigned CHAR_W    = 4;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned MEM_WORDS = 80;

  // Chip-select field inside the SRC X2 nibble
  localparam int unsigned CS_HI = 3;
  localparam int unsigned CS_LO = 2;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  // Low nibble is the OPA of the I/O instruction; IO_NONE sits outside that range
  typedef enum logic [4:0] {
    OP_WRM  = 5'h00,
    OP_WMP  = 5'h01,
    OP_WRR  = 5'h02,
    OP_WPM  = 5'h03,
    OP_WR0  = 5'h04,
    OP_WR1  = 5'h05,
    OP_WR2  = 5'h06,
    OP_WR3  = 5'h07,
    OP_SBM  = 5'h08,
    OP_RDM  = 5'h09,
    OP_RDR  = 5'h0A,
    OP_ADM  = 5'h0B,
    OP_RD0  = 5'h0C,
    OP_RD1  = 5'h0D,
    OP_RD2  = 5'h0E,
    OP_RD3  = 5'h0F,
    IO_NONE = 5'h10
  } io_op_e;

  function automatic logic op_is_read(input io_op_e op);
    return op inside {OP_SBM, OP_RDM, OP_ADM, OP_RD0, OP_RD1, OP_RD2, OP_RD3};
  endfunction

  function automatic logic op_is_status(input io_op_e op);
    return op inside {OP_WR0, OP_WR1, OP_WR2, OP_WR3, OP_RD0, OP_RD1, OP_RD2, OP_RD3};
  endfunction

  function automatic logic op_writes_mem(input io_op_e op);
    return op inside {OP_WRM, OP_WR0, OP_WR1, OP_WR2, OP_WR3};
  endfunction

endpackage

// File: rtl/ram4002_responder_if.sv
// Bus-side control and observation signals of one 4002 RAM responder.
interface ram4002_responder_if;
  import ram4002_responder_pkg::*;

  logic             phi_en;
  logic             sync;
  logic             cm_ram;
  logic [NIB_W-1:0] oport;
  logic             drv_en;

  modport master (output phi_en, sync, cm_ram, input oport, drv_en);
  modport slave  (input phi_en, sync, cm_ram, output oport, drv_en);
endinterface

// File: rtl/ram4002_responder_phase_seq.sv
// MCS-4 instruction-cycle phase tracker: advances one phase per phi_en and
// resynchronises to A1 on SYNC; flags cycles entered through an early SYNC.
module ram4002_responder_phase_seq
  import ram4002_responder_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   phi_en,
  input  logic   sync,
  output phase_e phase,
  output logic   synced,
  output logic   aborted
);

  phase_e phase_d;
  logic   synced_d;
  logic   aborted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= PH_X3;
      synced  <= 1'b0;
      aborted <= 1'b0;
    end else begin
      phase   <= phase_d;
      synced  <= synced_d;
      aborted <= aborted_d;
    end
  end

  // A SYNC outside X3 truncates the cycle; the cycle it starts may not execute
  always_comb begin
    phase_d   = phase;
    synced_d  = synced;
    aborted_d = aborted;
    if (phi_en) begin
      if (sync) begin
        phase_d   = PH_A1;
        synced_d  = 1'b1;
        aborted_d = (phase != PH_X3);
      end else begin
        phase_d = phase_e'(3'(phase + 3'd1));
        if (phase == PH_X3) begin
          aborted_d = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ram4002_responder.sv
// One 4002-style RAM chip on the MCS-4 bus: SRC address latch, I/O opcode
// decode, 80-nibble storage, output port and X2 read drive of the shared bus.
module ram4002_responder
  import ram4002_responder_pkg::*;
#(
  parameter logic [1:0]       CHIP_ID   = 2'd0,
  parameter logic [NIB_W-1:0] OPORT_RST = 4'h0
) (
  input  logic               sysclk,
  input  logic               poc,
  inout  wire  [NIB_W-1:0]   data,
  ram4002_responder_if.slave bus
);

  phase_e phase;
  logic   synced;
  logic   aborted;

  ram4002_responder_phase_seq u_seq (
    .clk     (sysclk),
    .rst     (poc),
    .phi_en  (bus.phi_en),
    .sync    (bus.sync),
    .phase   (phase),
    .synced  (synced),
    .aborted (aborted)
  );

  logic              sel_q;
  logic [REG_W-1:0]  reg_q;
  logic [CHAR_W-1:0] char_q;
  logic              src_pend_q;
  io_op_e            io_op_q;
  logic [NIB_W-1:0]  oport_q;
  logic [NIB_W-1:0]  rd_q;
  logic              drv_q;

  logic [NIB_W-1:0]  mem [MEM_WORDS];

  logic              live;
  logic              enter_a1;
  logic              src_x2;
  logic              char_x3;
  logic              op_m2;
  logic              exec;
  logic              drive_next;
  logic              mem_we;
  logic [1:0]        stat_idx;
  logic [ADDR_W-1:0] addr;

  // Bus strobes, all qualified by the phi_en that leaves the named phase
  always_comb begin
    live       = bus.phi_en && synced;
    enter_a1   = bus.phi_en && (bus.sync || (phase == PH_X3));
    src_x2     = live && (phase == PH_X2) && bus.cm_ram;
    char_x3    = live && (phase == PH_X3) && src_pend_q;
    op_m2      = live && (phase == PH_M2) && !bus.sync;
    exec       = live && (phase == PH_X2) && !bus.sync && !aborted && sel_q &&
                 (io_op_q != IO_NONE);
    drive_next = live && (phase == PH_X1) && !bus.sync && !aborted && sel_q &&
                 op_is_read(io_op_q);
    mem_we     = exec && op_writes_mem(io_op_q);
    stat_idx   = 2'(io_op_q);
    // Status nibbles live above the 64 main nibbles: 64 + reg*4 + n
    addr       = op_is_status(io_op_q) ? {1'b1, 2'b00, reg_q, stat_idx}
                                       : {1'b0, reg_q, char_q};
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      sel_q      <= 1'b0;
      reg_q      <= '0;
      char_q     <= '0;
      src_pend_q <= 1'b0;
      io_op_q    <= IO_NONE;
      oport_q    <= OPORT_RST;
      drv_q      <= 1'b0;
      rd_q       <= '0;
    end else begin
      if (src_x2) begin
        sel_q <= (data[CS_HI:CS_LO] == CHIP_ID);
        reg_q <= data[REG_W-1:0];
      end
      if (char_x3) begin
        char_q <= data;
      end
      if (src_x2) begin
        src_pend_q <= 1'b1;
      end else if (enter_a1) begin
        src_pend_q <= 1'b0;
      end
      if (enter_a1) begin
        io_op_q <= IO_NONE;
      end else if (op_m2) begin
        io_op_q <= (bus.cm_ram && sel_q) ? io_op_e'({1'b0, data}) : IO_NONE;
      end
      if (exec && (io_op_q == OP_WMP)) begin
        oport_q <= data;
      end
      // Drive flag and read value are captured on the phi_en entering X2 and
      // dropped on the phi_en leaving it
      if (bus.phi_en) begin
        drv_q <= drive_next;
        rd_q  <= mem[addr];
      end
    end
  end

  // Storage has no reset; writes only happen while synced, which poc clears
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem[addr] <= data;
    end
  end

  assign bus.oport  = oport_q;
  assign bus.drv_en = drv_q;
  assign data       = drv_q ? rd_q : {NIB_W{1'bz}};

endmodule

// File: tb/tb_ram4002_responder.sv
// Directed and random MCS-4 instruction cycles against a cycle-level model of
// one 4002 RAM chip (CHIP_ID=1).
module tb_ram4002_responder;
  import ram4002_responder_pkg::*;

  localparam logic [1:0] CHIP = 2'd1;
  localparam logic [3:0] ORST = 4'h3;

  logic       clk = 1'b0;
  logic       poc;
  logic       tb_oe;
  logic [3:0] tb_dat;
  wire  [3:0] data;
  int         total = 0;
  int         bad = 0;

  ram4002_responder_if bus ();

  ram4002_responder #(.CHIP_ID(CHIP), .OPORT_RST(ORST)) dut (
    .sysclk (clk),
    .poc    (poc),
    .data   (data),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  assign data = tb_oe ? tb_dat : 4'bzzzz;

  // Reference model: chip state at instruction-cycle granularity
  logic [3:0] m_main   [4][16];
  bit         m_main_k [4][16];
  logic [3:0] m_stat   [4][4];
  bit         m_stat_k [4][4];
  logic [3:0] m_oport;
  bit         m_sel;
  logic [1:0] m_reg;
  logic [3:0] m_chr;
  bit         m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_oport = ORST;
    m_sel   = 1'b0;
    m_reg   = 2'd0;
    m_chr   = 4'd0;
    m_pend  = 1'b0;
  endtask

  // One phi_en pulse carrying the values sampled as the current phase ends
  task automatic step(input bit s, input bit cm, input bit oe, input logic [3:0] v);
    bus.sync   = s;
    bus.cm_ram = cm;
    tb_oe      = oe;
    tb_dat     = v;
    bus.phi_en = 1'b1;
    @(posedge clk); #1;
    bus.phi_en = 1'b0;
    bus.sync   = 1'b0;
    bus.cm_ram = 1'b0;
    tb_oe      = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full instruction cycle starting from X3: X3 data, M2 opcode, X2 data
  task automatic cycle(input logic [3:0] x3v, input bit m2cm, input logic [3:0] opa,
                       input bit x2cm, input logic [3:0] x2v, input string tag);
    bit         has_op;
    bit         rd;
    bit         known;
    logic [3:0] exp_val;
    logic [1:0] n;
    step(1'b1, 1'b0, 1'b1, x3v);
    if (m_pend) begin
      m_chr  = x3v;
      m_pend = 1'b0;
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, m2cm, 1'b1, opa);
    has_op = m2cm && m_sel;
    n      = opa[1:0];
    rd     = has_op && (opa == 4'h8 || opa == 4'h9 || opa == 4'hB || opa >= 4'hC);
    if (opa >= 4'hC) begin
      exp_val = m_stat[m_reg][n];
      known   = m_stat_k[m_reg][n];
    end else begin
      exp_val = m_main[m_reg][m_chr];
      known   = m_main_k[m_reg][m_chr];
    end
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check({tag, " drv_en"}, 32'(bus.drv_en), 32'(rd));
    if (rd && known) check({tag, " rd_data"}, 32'(data), 32'(exp_val));
    step(1'b0, x2cm, !rd, x2v);
    if (has_op) begin
      case (opa)
        4'h0: begin
          m_main[m_reg][m_chr]   = x2v;
          m_main_k[m_reg][m_chr] = 1'b1;
        end
        4'h1: m_oport = x2v;
        4'h4, 4'h5, 4'h6, 4'h7: begin
          m_stat[m_reg][n]   = x2v;
          m_stat_k[m_reg][n] = 1'b1;
        end
        default: ;
      endcase
    end
    if (x2cm) begin
      m_sel  = (x2v[3:2] == CHIP);
      m_reg  = x2v[1:0];
      m_pend = 1'b1;
    end
    check({tag, " oport"}, 32'(bus.oport), 32'(m_oport));
  endtask

  initial begin
    logic [3:0] v;
    poc        = 1'b1;
    tb_oe      = 1'b0;
    tb_dat     = 4'h0;
    bus.phi_en = 1'b0;
    bus.sync   = 1'b0;
    bus.cm_ram = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) m_main_k[r][c] = 1'b0;
      for (int c = 0; c < 4; c++)  m_stat_k[r][c] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 poc = 1'b0;
    @(posedge clk); #1;
    check("reset drv_en", 32'(bus.drv_en), 32'(0));
    check("reset oport", 32'(bus.oport), 32'(ORST));
    check("reset phase", 32'(dut.phase), 32'(PH_X3));

    // Unsynced bus traffic, including a matching SRC, must leave the chip idle
    repeat (5) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("unsynced drv_en", 32'(bus.drv_en), 32'(0));
    step(1'b0, 1'b1, 1'b1, {CHIP, 2'b00});
    check("unsynced oport", 32'(bus.oport), 32'(ORST));
    cycle(4'h0, 1'b1, 4'h1, 1'b0, 4'hE, "wmp_unselected");

    // SRC reg 2 char 9, WRM 0xA, RDM
    cycle(4'h0, 1'b0, 4'h0, 1'b1, 4'b0110, "src_r2");
    cycle(4'h9, 1'b1, 4'h0, 1'b0, 4'hA, "wrm_a");
    check("src reg", 32'(dut.reg_q), 32'(2));
    check("src char", 32'(dut.char_q), 32'(9));
    cycle(4'h0, 1'b1, 4'h9, 1'b0, 4'h0, "rdm_a");

    // SRC for chip 2 deselects; writes and reads are ignored
    cycle(4'h0, 1'b0, 4'h0, 1'b1, 4'b1001, "src_other");
    cycle(4'h9, 1'b1, 4'h0, 1'b0, 4'h4, "wrm_desel");
    cycle(4'h0, 1'b1, 4'h9, 1'b0, 4'h0, "rdm_desel");
    cycle(4'h0, 1'b0, 4'h0, 1'b1, {CHIP, 2'b10}, "src_back");
    cycle(4'h9, 1'b1, 4'h9, 1'b0, 4'h0, "rdm_kept");

    // Status characters of reg 3
    cycle(4'h0, 1'b0, 4'h0, 1'b1, {CHIP, 2'b11}, "src_r3");
    cycle(4'h2, 1'b1, 4'h5, 1'b0, 4'h7, "wr1");
    cycle(4'h0, 1'b1, 4'h6, 1'b0, 4'h5, "wr2");
    cycle(4'h0, 1'b1, 4'hE, 1'b0, 4'h0, "rd2");
    cycle(4'h0, 1'b1, 4'hD, 1'b0, 4'h0, "rd1");

    // Output port and ROM-only opcodes
    cycle(4'h0, 1'b1, 4'h1, 1'b0, 4'hC, "wmp_c");
    cycle(4'h0, 1'b1, 4'h2, 1'b0, 4'h6, "rom_2");
    cycle(4'h0, 1'b1, 4'hA, 1'b0, 4'h0, "rom_a");

    // Power-on clear in the middle of an RDM drive
    cycle(4'h0, 1'b0, 4'h0, 1'b1, {CHIP, 2'b10}, "src_poc");
    step(1'b1, 1'b0, 1'b1, 4'h9);
    m_chr  = 4'h9;
    m_pend = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h9);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("poc_pre drv_en", 32'(bus.drv_en), 32'(1));
    check("poc_pre rd_data", 32'(data), 32'(m_main[2][9]));
    #2 poc = 1'b1;
    #1;
    check("poc drv_en", 32'(bus.drv_en), 32'(0));
    check("poc oport", 32'(bus.oport), 32'(ORST));
    check("poc phase", 32'(dut.phase), 32'(PH_X3));
    #1 poc = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Resync, then an early SYNC at M1 aborts the following cycle
    cycle(4'h0, 1'b0, 4'h0, 1'b1, {CHIP, 2'b00}, "resync_src");
    step(1'b1, 1'b0, 1'b1, 4'h5);
    m_chr  = 4'h5;
    m_pend = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("early_sync phase", 32'(dut.phase), 32'(PH_A1));
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("early_sync drv_en", 32'(bus.drv_en), 32'(0));
    step(1'b0, 1'b0, 1'b1, 4'hB);
    check("early_sync oport", 32'(bus.oport), 32'(m_oport));
    cycle(4'h0, 1'b1, 4'h1, 1'b0, 4'hD, "wmp_after_abort");

    // Random traffic: SRC cycles biased toward this chip, otherwise I/O cycles
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = {($urandom_range(0, 2) != 0) ? CHIP : 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3))};
        cycle(4'($urandom_range(0, 15)), 1'b0, 4'h0, 1'b1, v, "rnd_src");
      end else begin
        cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
              4'($urandom_range(0, 15)), 1'b0, 4'($urandom_range(0, 15)), "rnd_io");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
